// File: rtl/sha_padder.sv
// FIPS 180-4 message padder: byte stream in, 512/1024-bit blocks out for sha_engine.
// The sha package supplies the mode encoding shared with the engine.
package sha;
    typedef enum logic [2:0] {
        SHA1, SHA224, SHA256, SHA384, SHA512, SHA512_224, SHA512_256
    } mode;

    function automatic logic is_wide(mode m);
        return m inside {SHA384, SHA512, SHA512_224, SHA512_256};
    endfunction
endpackage

module sha_padder (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_data,
    input  logic           in_last,
    input  sha::mode       in_mode,
    output logic           blk_valid,
    input  logic           blk_ready,
    output logic [1023:0]  blk_data,
    output sha::mode       blk_mode,
    output logic           blk_first,
    output logic           blk_last
);
    typedef enum logic [2:0] {IDLE, FILL, PAD, EMIT_DATA, EMIT_SPILL, EMIT_FINAL} state_t;

    state_t       state;
    logic [7:0]   offset;
    logic [60:0]  count;
    logic         first_pending;
    logic         marker_pending;

    logic         wide;
    logic         accept;
    logic [7:0]   nbytes;
    logic [7:0]   len_bytes;
    logic [9:0]   top;
    logic [10:0]  byte_top;
    logic [63:0]  len_bits;

    always_comb begin
        wide      = sha::is_wide((state == IDLE) ? in_mode : blk_mode);
        nbytes    = wide ? 8'd128 : 8'd64;
        len_bytes = wide ? 8'd16 : 8'd8;
        top       = wide ? 10'd1023 : 10'd511;
        byte_top  = {1'b0, top} - {offset, 3'b000};
        len_bits  = {count, 3'b000};
        accept    = in_valid & in_ready;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            blk_valid      <= 1'b0;
            blk_data       <= '0;
            blk_mode       <= sha::SHA1;
            blk_first      <= 1'b0;
            blk_last       <= 1'b0;
            offset         <= '0;
            count          <= '0;
            first_pending  <= 1'b0;
            marker_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        blk_mode       <= in_mode;
                        blk_data       <= '0;
                        blk_data[top -: 8] <= in_data;
                        offset         <= 8'd1;
                        count          <= 61'd1;
                        first_pending  <= 1'b1;
                        marker_pending <= 1'b0;
                        if (in_last) begin
                            state    <= PAD;
                            in_ready <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        blk_data[byte_top[9:0] -: 8] <= in_data;
                        offset <= offset + 8'd1;
                        count  <= count + 61'd1;
                        if (in_last) begin
                            state    <= PAD;
                            in_ready <= 1'b0;
                        end else if (offset + 8'd1 == nbytes) begin
                            state     <= EMIT_DATA;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_last  <= 1'b0;
                            blk_first <= first_pending;
                        end
                    end
                end
                PAD: begin
                    // Bytes above the marker are already zero: the buffer is cleared
                    // at message start and after every emitted data block.
                    blk_valid <= 1'b1;
                    blk_first <= first_pending;
                    if (offset < nbytes)
                        blk_data[byte_top[9:0] -: 8] <= 8'h80;
                    if (offset + 8'd1 <= nbytes - len_bytes) begin
                        blk_data[63:0] <= len_bits;
                        blk_last       <= 1'b1;
                        state          <= EMIT_FINAL;
                    end else begin
                        marker_pending <= (offset == nbytes);
                        blk_last       <= 1'b0;
                        state          <= EMIT_SPILL;
                    end
                end
                EMIT_DATA: begin
                    if (blk_ready) begin
                        blk_valid     <= 1'b0;
                        blk_first     <= 1'b0;
                        blk_data      <= '0;
                        offset        <= '0;
                        first_pending <= 1'b0;
                        in_ready      <= 1'b1;
                        state         <= FILL;
                    end
                end
                EMIT_SPILL: begin
                    if (blk_ready) begin
                        blk_data <= '0;
                        if (marker_pending)
                            blk_data[top -: 8] <= 8'h80;
                        blk_data[63:0] <= len_bits;
                        blk_first      <= 1'b0;
                        blk_last       <= 1'b1;
                        first_pending  <= 1'b0;
                        state          <= EMIT_FINAL;
                    end
                end
                EMIT_FINAL: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_first <= 1'b0;
                        blk_last  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
